// File: rtl/parallel_sum_ctrl_if.sv
// Stream, adder and result-port bundle for parallel_sum_ctrl.
// slave = controller view, master = environment view.
interface parallel_sum_ctrl_if #(
    parameter int NUM_WORDS = 256,
    parameter int DATA_W    = 32,
    parameter int SUM_W     = 40
) ();
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    logic [DATA_W-1:0]           s_data;
    logic                        s_valid;
    logic                        s_last;
    logic                        s_ready;
    logic [NUM_WORDS*DATA_W-1:0] add_data;
    logic                        add_valid;
    logic [SUM_W-1:0]            add_sum;
    logic                        add_sum_valid;
    logic [SUM_W-1:0]            m_sum;
    logic [CNT_W-1:0]            m_words;
    logic                        m_valid;
    logic                        m_ready;
    logic                        err;

    modport slave (
        input  s_data, s_valid, s_last, add_sum, add_sum_valid, m_ready,
        output s_ready, add_data, add_valid, m_sum, m_words, m_valid, err
    );

    modport master (
        output s_data, s_valid, s_last, add_sum, add_sum_valid, m_ready,
        input  s_ready, add_data, add_valid, m_sum, m_words, m_valid, err
    );
endinterface

// File: rtl/parallel_sum_ctrl.sv
// Packs a word stream into one adder vector, fires the adder tree and
// buffers its results behind credit-based flow control.
module parallel_sum_ctrl #(
    parameter int NUM_WORDS  = 256,
    parameter int DATA_W     = 32,
    parameter int SUM_W      = 40,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    parallel_sum_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int CR_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {FILL, FIRE, WAIT_CREDIT} state_e;

    state_e                      state_q, state_d;
    logic [NUM_WORDS*DATA_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            nwords_q, nwords_d;
    logic [CR_W-1:0]             credits_q, credits_d;
    logic [CR_W-1:0]             outst_q, outst_d;
    logic [CR_W-1:0]             cnt_q, cnt_d;
    logic [PTR_W-1:0]            rptr_q, swptr_q, twptr_q;
    logic [SUM_W-1:0]            sum_mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]            tag_mem_q [FIFO_DEPTH];
    logic                        err_q;

    logic fire, ready, pop, cap, stale;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        nwords_d = nwords_q;
        fire     = 1'b0;
        ready    = 1'b0;
        unique case (state_q)
            FILL: begin
                ready = 1'b1;
                if (bus.s_valid) begin
                    vec_d[int'(idx_q)*DATA_W +: DATA_W] = bus.s_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX || bus.s_last) begin
                        nwords_d = idx_q + 1'b1;
                        state_d  = (credits_q != '0) ? FIRE : WAIT_CREDIT;
                    end
                end
            end
            WAIT_CREDIT: begin
                if (credits_q != '0) state_d = FIRE;
            end
            FIRE: begin
                fire    = 1'b1;
                vec_d   = '0;
                idx_d   = '0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Credits track free result slots; the adder itself can never stall.
    always_comb begin
        pop       = (cnt_q != '0) && bus.m_ready;
        cap       = bus.add_sum_valid && (outst_q != '0);
        stale     = bus.add_sum_valid && (outst_q == '0);
        credits_d = credits_q - CR_W'(fire) + CR_W'(pop);
        outst_d   = outst_q + CR_W'(fire) - CR_W'(cap);
        cnt_d     = cnt_q + CR_W'(cap) - CR_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            vec_q     <= '0;
            idx_q     <= '0;
            nwords_q  <= '0;
            credits_q <= CR_W'(FIFO_DEPTH);
            outst_q   <= '0;
            cnt_q     <= '0;
            rptr_q    <= '0;
            swptr_q   <= '0;
            twptr_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                sum_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            idx_q     <= idx_d;
            nwords_q  <= nwords_d;
            credits_q <= credits_d;
            outst_q   <= outst_d;
            cnt_q     <= cnt_d;
            if (stale) err_q <= 1'b1;
            if (cap) begin
                sum_mem_q[swptr_q] <= bus.add_sum;
                swptr_q <= inc(swptr_q);
            end
            if (fire) begin
                tag_mem_q[twptr_q] <= nwords_q;
                twptr_q <= inc(twptr_q);
            end
            if (pop) rptr_q <= inc(rptr_q);
        end
    end

    // Tags and results pop together, so one read pointer serves both.
    assign bus.s_ready   = ready;
    assign bus.add_valid = fire;
    assign bus.add_data  = vec_q;
    assign bus.m_valid   = (cnt_q != '0);
    assign bus.m_sum     = sum_mem_q[rptr_q];
    assign bus.m_words   = tag_mem_q[rptr_q];
    assign bus.err       = err_q;
endmodule

// File: tb/tb_parallel_sum_ctrl.sv
// Bench for parallel_sum_ctrl: latency-3 adder model plus a queue of
// expected (sum, word-count) pairs built from the words as they are sent.
module tb_parallel_sum_ctrl;
    localparam int NW = 256;
    localparam int DW = 32;
    localparam int SW = 40;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parallel_sum_ctrl_if #(.NUM_WORDS(NW), .DATA_W(DW), .SUM_W(SW)) bus ();

    parallel_sum_ctrl #(
        .NUM_WORDS(NW), .DATA_W(DW), .SUM_W(SW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // adder tree model
    logic [SW-1:0] pipe_s [3];
    logic [2:0]    pipe_v = '0;
    logic          inj_v = 1'b0;
    logic [SW-1:0] inj_s = '0;
    logic [SW-1:0] acc;

    always @(posedge clk) begin
        acc = '0;
        for (int j = 0; j < NW; j++) acc = acc + SW'(bus.add_data[j*DW +: DW]);
        pipe_s[0] <= acc;
        pipe_s[1] <= pipe_s[0];
        pipe_s[2] <= pipe_s[1];
        pipe_v    <= {pipe_v[1:0], bus.add_valid};
    end

    assign bus.add_sum_valid = pipe_v[2] | inj_v;
    assign bus.add_sum       = inj_v ? inj_s : pipe_s[2];

    // reference results and monitor
    logic [SW-1:0] exp_s [$];
    int            exp_n [$];
    logic [SW-1:0] es;
    int            en;
    int            fires = 0;
    logic [NW*DW-1:0] last_vec = '0;

    always @(negedge clk) begin
        if (bus.add_valid === 1'b1) begin
            fires++;
            last_vec = bus.add_data;
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            if (exp_s.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                es = exp_s.pop_front();
                en = exp_n.pop_front();
                check("m_sum", bus.m_sum, es);
                check("m_words", bus.m_words, en);
            end
        end
    end

    // 0: always ready, 1: never, 2: random, 3: manual
    int rmode = 3;
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: bus.m_ready = 1'b1;
            1: bus.m_ready = 1'b0;
            2: bus.m_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit last);
        bit done = 0;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) done = 1;
            step();
        end
        if (!done) check("s_ready_timeout", 0, 1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // kind 0: 1..n, 1: all ones, 2: random, 3: 5,6,7..
    task automatic send_vec(input int n, input int kind, input int gapmax);
        logic [SW-1:0] sum = '0;
        logic [DW-1:0] w;
        bit last;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: w = DW'(i + 1);
                1: w = '1;
                3: w = DW'(i + 5);
                default: w = $urandom;
            endcase
            if (gapmax > 0) repeat ($urandom_range(0, gapmax)) step();
            last = (i == n - 1) && (n < NW || $urandom_range(0, 1) == 1);
            send_word(w, last);
            sum = sum + SW'(w);
        end
        exp_s.push_back(sum);
        exp_n.push_back(n);
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 4000; c++) begin
            if (exp_s.size() == 0) break;
            step();
        end
        repeat (6) step();
        check(tag, exp_s.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int f0;
    int n;
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_add_valid", bus.add_valid, 0);
        check("rst_add_data", |bus.add_data, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_sum", bus.m_sum, 0);
        check("rst_m_words", bus.m_words, 0);
        check("rst_err", bus.err, 0);
        step();
        rst_n = 1'b1;
        step();

        // full counting vector
        rmode = 0;
        f0 = fires;
        send_vec(NW, 0, 0);
        wait_drain("t1_drain");
        check("t1_fires", fires - f0, 1);

        // short vector 5,6,7
        send_vec(3, 3, 0);
        wait_drain("t2_drain");
        check("t2_w0", last_vec[0 +: DW], 5);
        check("t2_w2", last_vec[2*DW +: DW], 7);
        check("t2_tail_zero", |(last_vec >> (3*DW)), 0);
        send_vec(10, 2, 1);
        wait_drain("t2_next_drain");

        // credit exhaustion
        rmode = 1;
        step();
        f0 = fires;
        repeat (5) send_vec(NW, 2, 0);
        repeat (10) step();
        @(negedge clk);
        check("t3_fires4", fires - f0, 4);
        check("t3_s_ready", bus.s_ready, 0);
        check("t3_m_valid", bus.m_valid, 1);
        step();
        rmode = 3;
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("t3_no_early_fire", bus.add_valid, 0);
        @(negedge clk);
        check("t3_fire_after_credit", bus.add_valid, 1);
        @(negedge clk);
        check("t3_fire_one_cycle", bus.add_valid, 0);
        rmode = 0;
        wait_drain("t3_drain");
        check("t3_fires5", fires - f0, 5);

        // all-ones vector
        send_vec(NW, 1, 0);
        wait_drain("t4_drain");
        check("t4_err", bus.err, 0);

        // reset mid-vector, then a stale result
        for (int i = 0; i < 100; i++) send_word($urandom, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_s_ready", bus.s_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        inj_s = 40'h12345;
        inj_v = 1'b1;
        step();
        inj_v = 1'b0;
        @(negedge clk);
        check("t5_err", bus.err, 1);
        check("t5_m_valid", bus.m_valid, 0);
        step();
        send_vec(NW, 2, 0);
        wait_drain("t5_drain");
        check("t5_err_sticky", bus.err, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", bus.err, 0);
        step();
        rst_n = 1'b1;
        step();

        // simultaneous push and pop at count 1
        rmode = 3;
        bus.m_ready = 1'b0;
        send_vec(4, 2, 0);
        for (int c = 0; c < 50; c++) begin
            if (bus.m_valid) break;
            step();
        end
        check("t6_first_valid", bus.m_valid, 1);
        send_vec(6, 2, 0);
        for (int c = 0; c < 50; c++) begin
            if (bus.add_sum_valid) break;
            step();
        end
        check("t6_sum_strobe", bus.add_sum_valid, 1);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("t6_count_kept", bus.m_valid, 1);
        check("t6_head_words", bus.m_words, 6);
        step();
        rmode = 0;
        wait_drain("t6_drain");

        // random traffic
        rmode = 2;
        for (int v = 0; v < 200; v++) begin
            n = ($urandom_range(0, 7) == 0) ? NW : $urandom_range(1, 40);
            send_vec(n, 2, 2);
        end
        wait_drain("rand_drain");
        check("rand_err", bus.err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
